// File: rtl/ternary_decompress_if.sv
// Stream interface for ternary_decompress: compressed-byte input side and
// trit output side. err_o exists only when TERNARY_DECOMPRESS_ERR_EN is defined.
interface ternary_decompress_if #(
  parameter int CODE_WIDTH = 8
);
  logic [CODE_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [1:0]            trit_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;
`ifdef TERNARY_DECOMPRESS_ERR_EN
  logic                  err_o;
`endif

  // Decompressor side
  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output trit_o,
    output valid_o,
    input  ready_i,
`ifdef TERNARY_DECOMPRESS_ERR_EN
    output err_o,
`endif
    output last_o
  );

  // Producer / consumer side
  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  trit_o,
    input  valid_o,
    output ready_i,
`ifdef TERNARY_DECOMPRESS_ERR_EN
    input  err_o,
`endif
    input  last_o
  );
endinterface

// File: rtl/ternary_decompress.sv
// ternary_decompress: unpacks one 8-bit base-3 byte into 5 trits, one per
// cycle, t_0 first. Trit encoding: 2'b11=-1, 2'b00=0, 2'b01=+1.
// Optional macro TERNARY_DECOMPRESS_ERR_EN adds err_o and forces trits of
// illegal bytes (>242) to zero; without it illegal bytes decode arithmetically.
module ternary_decompress #(
  parameter int N_TRITS    = 5,
  parameter int CODE_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  ternary_decompress_if.slave bus
);

  if (N_TRITS != 5) begin : g_bad_n_trits
    $error("ternary_decompress: only N_TRITS=5 is supported");
  end
  if (CODE_WIDTH != 8) begin : g_bad_code_width
    $error("ternary_decompress: only CODE_WIDTH=8 is supported");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'd4;

  // Exact floor(x/3) for 8-bit x: (x*171)>>9, built from shifts and adds.
  function automatic logic [7:0] div3(input logic [7:0] x);
    logic [16:0] acc;
    acc = {9'd0, x} + ({9'd0, x} << 1) + ({9'd0, x} << 3)
        + ({9'd0, x} << 5) + ({9'd0, x} << 7);
    return acc[16:9];
  endfunction

  // Remainder from the quotient: x - 3*q, always 0..2.
  function automatic logic [1:0] mod3(input logic [7:0] x, input logic [7:0] q);
    logic [9:0] r;
    r = {2'b00, x} - ({2'b00, q} << 1) - {2'b00, q};
    return r[1:0];
  endfunction

  // Base-3 digit d maps to trit d-1 in two's complement.
  function automatic logic signed [1:0] encode_trit(input logic [1:0] digit);
    logic signed [1:0] t;
    case (digit)
      2'd0:    t = 2'sb11;
      2'd1:    t = 2'sb00;
      default: t = 2'sb01;
    endcase
    return t;
  endfunction

  logic [0:0]        state;
  logic [7:0]        rem;
  logic [2:0]        cnt;
  logic [7:0]        rem_div;
  logic [1:0]        rem_digit;
  logic signed [1:0] trit;
  logic              emit;
  logic              out_fire;
  logic              last_acc;
  logic              accept;
  logic              load;
`ifdef TERNARY_DECOMPRESS_ERR_EN
  logic              err;
`endif

  assign rem_div   = div3(rem);
  assign rem_digit = mod3(rem, rem_div);
  assign trit      = encode_trit(rem_digit);

  assign emit      = (state == EMIT);
  assign out_fire  = emit && bus.ready_i;
  assign last_acc  = out_fire && (cnt == LAST_IDX);
  assign accept    = !emit || last_acc;
  assign load      = bus.valid_i && accept;

  assign bus.ready_o = accept;
  assign bus.valid_o = emit;
  assign bus.last_o  = emit && (cnt == LAST_IDX);
`ifdef TERNARY_DECOMPRESS_ERR_EN
  assign bus.err_o   = emit && err;
  assign bus.trit_o  = (emit && !err) ? trit : 2'b00;
`else
  assign bus.trit_o  = emit ? trit : 2'b00;
`endif

  // Group sequencing: load a byte, shift out one base-3 digit per accepted trit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      rem   <= 8'd0;
      cnt   <= 3'd0;
    end else if (clear_i) begin
      state <= IDLE;
      rem   <= 8'd0;
      cnt   <= 3'd0;
    end else if (load) begin
      state <= EMIT;
      rem   <= bus.data_i;
      cnt   <= 3'd0;
    end else if (last_acc) begin
      state <= IDLE;
      rem   <= 8'd0;
      cnt   <= 3'd0;
    end else if (out_fire) begin
      rem   <= rem_div;
      cnt   <= cnt + 3'd1;
    end
  end

`ifdef TERNARY_DECOMPRESS_ERR_EN
  // Illegal-code flag, captured at byte load and held for the whole group.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (clear_i) begin
      err <= 1'b0;
    end else if (load) begin
      err <= (bus.data_i > 8'd242);
    end
  end
`endif

endmodule
